bht_update_scheduler: RTL and testbench

//  Buffers resolved-branch updates from execute and drains them, one per cycle, into the

---
 rtl/bht_update_scheduler_pkg.sv | 13 +
 rtl/bht_update_scheduler_fifo.sv | 59 +++++
 rtl/bht_update_scheduler.sv | 75 +++++++
 tb/tb_bht_update_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bht_update_scheduler_pkg.sv
// Shared PC slicing constants and update record for the BHT update path.
// Predictor and scheduler both slice the PC with these so indices always agree.
package bht_update_scheduler_pkg;
  localparam int PC_WIDTH      = 16;
  localparam int BHT_INDEX_LSB = 2;
  localparam int DEF_INDEX_LEN = 7;
  localparam int DEF_TAG_LEN   = PC_WIDTH - BHT_INDEX_LSB - DEF_INDEX_LEN;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                outcome;
  } upd_t;
endpackage

// File: rtl/bht_update_scheduler_fifo.sv
// Update queue: circular buffer with wrap-bit pointers, flush-to-empty and a
// per-entry BHT index compare vector for the read-side hazard check.
module bp_update_fifo
  import bht_update_scheduler_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int INDEX_LEN = DEF_INDEX_LEN
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  upd_t                   i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [INDEX_LEN-1:0]   i_rd_idx,
  output logic                   o_full,
  output logic                   o_empty,
  output upd_t                   o_head,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic [DEPTH-1:0]       o_match
);
  localparam int AW = $clog2(DEPTH);

  upd_t        r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: validity comes from the pointers alone.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_occupancy = r_wr_ptr - r_rd_ptr;
  assign o_head      = r_mem[r_rd_ptr[AW-1:0]];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [AW-1:0] w_off;
    logic          w_valid;
    assign w_off      = AW'(i) - r_rd_ptr[AW-1:0];
    assign w_valid    = ({1'b0, w_off} < o_occupancy);
    assign o_match[i] = w_valid &&
                        (r_mem[i].pc[BHT_INDEX_LSB +: INDEX_LEN] == i_rd_idx);
  end
endmodule

// File: rtl/bht_update_scheduler.sv
// Drains queued resolved-branch updates one per cycle into the BHT write port,
// and flags predictor reads whose index still has a write pending.
module bht_update_scheduler
  import bht_update_scheduler_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int INDEX_LEN = DEF_INDEX_LEN
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_upd_valid,
  input  logic [PC_WIDTH-1:0]    i_upd_pc,
  input  logic                   i_upd_outcome,
  output logic                   o_upd_ready,
  input  logic                   i_flush,
  input  logic                   i_wr_hold,
  input  logic [PC_WIDTH-1:0]    i_rd_pc,
  output logic                   o_rd_hazard,
  output logic                   o_wr_en,
  output logic [PC_WIDTH-1:0]    o_wr_pc,
  output logic                   o_wr_outcome,
  output logic [$clog2(DEPTH):0] o_occupancy
);
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  upd_t                 w_head;
  upd_t                 w_push_data;
  logic [DEPTH-1:0]     w_match;
  logic [INDEX_LEN-1:0] w_rd_idx;
  logic                 w_issue_hit;

  logic                 r_wr_en;
  upd_t                 r_wr;

  assign w_rd_idx    = i_rd_pc[BHT_INDEX_LSB +: INDEX_LEN];
  assign w_push_data = '{pc: i_upd_pc, outcome: i_upd_outcome};
  // No pass-through: a full queue refuses even when it pops this cycle.
  assign o_upd_ready = !w_full;
  assign w_push      = i_upd_valid && !w_full && !i_flush;
  assign w_pop       = !w_empty && !i_wr_hold && !i_flush;

  bp_update_fifo #(.DEPTH(DEPTH), .INDEX_LEN(INDEX_LEN)) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (i_flush),
    .i_rd_idx    (w_rd_idx),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head),
    .o_occupancy (o_occupancy),
    .o_match     (w_match)
  );

  // Issue register: an entry already here completes even across a flush.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_en <= 1'b0;
      r_wr    <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) r_wr <= w_head;
    end
  end

  assign w_issue_hit  = r_wr_en && (r_wr.pc[BHT_INDEX_LSB +: INDEX_LEN] == w_rd_idx);
  assign o_rd_hazard  = (|w_match) || w_issue_hit;
  assign o_wr_en      = r_wr_en;
  assign o_wr_pc      = r_wr.pc;
  assign o_wr_outcome = r_wr.outcome;
endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed vector table for the update scheduler, plus a model-checked
// back-pressure run with random PCs.
module tb_bht_update_scheduler;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, upd_valid, upd_outcome, upd_ready, flush, wr_hold;
  logic        rd_hazard, wr_en, wr_outcome;
  logic [15:0] upd_pc, rd_pc, wr_pc;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  bht_update_scheduler #(.DEPTH(DEPTH), .INDEX_LEN(7)) dut (
    .i_clk(clk), .i_reset(rst), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_outcome(upd_outcome), .o_upd_ready(upd_ready), .i_flush(flush),
    .i_wr_hold(wr_hold), .i_rd_pc(rd_pc), .o_rd_hazard(rd_hazard),
    .o_wr_en(wr_en), .o_wr_pc(wr_pc), .o_wr_outcome(wr_outcome),
    .o_occupancy(occupancy)
  );

  typedef struct {
    logic        rst, v;
    logic [15:0] pc;
    logic        oc, fl, hold;
    logic [15:0] rdpc;
    logic        rdy, we;
    logic [15:0] wpc;
    logic        woc;
    logic [2:0]  occ;
    logic        hz;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nfail = 0;

  // model state for the back-pressure run
  logic [16:0] mq[$];
  logic        m_iss = 1'b0;
  logic [16:0] m_iss_e = '0;
  int          accepted = 0;

  function automatic vec_t mk(logic r, logic v, logic [15:0] pc, logic oc, logic fl,
                              logic hold, logic [15:0] rdpc, logic rdy, logic we,
                              logic [15:0] wpc, logic woc, logic [2:0] occ, logic hz);
    vec_t t;
    t.rst = r; t.v = v; t.pc = pc; t.oc = oc; t.fl = fl; t.hold = hold; t.rdpc = rdpc;
    t.rdy = rdy; t.we = we; t.wpc = wpc; t.woc = woc; t.occ = occ; t.hz = hz;
    return t;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [15:0] pc,
                       input logic oc, input logic fl, input logic hold,
                       input logic [15:0] rdpc);
    rst = r; upd_valid = v; upd_pc = pc; upd_outcome = oc;
    flush = fl; wr_hold = hold; rd_pc = rdpc;
  endtask

  function automatic logic [6:0] idx(input logic [15:0] pc);
    return pc[8:2];
  endfunction

  // One cycle against the queue model; inputs at negedge, checks 1ns later.
  task automatic model_cycle(input logic v, input logic hold);
    logic [15:0] pc;
    logic        oc, e_rdy, e_hz, acc, pop;
    pc = 16'($urandom);
    oc = 1'($urandom);
    drive(1'b0, v, pc, oc, 1'b0, hold, 16'hFFFC);
    #1;
    e_rdy = (mq.size() < DEPTH);
    e_hz  = m_iss && (idx(m_iss_e[16:1]) == idx(16'hFFFC));
    foreach (mq[k]) if (idx(mq[k][16:1]) == idx(16'hFFFC)) e_hz = 1'b1;
    nvec++;
    if (upd_ready !== e_rdy || wr_en !== m_iss || occupancy !== 3'(mq.size()) ||
        rd_hazard !== e_hz || (m_iss && {wr_pc, wr_outcome} !== m_iss_e)) begin
      nfail++;
      $display("FAIL bp cycle %0d: got rdy=%b we=%b pc=%h oc=%b occ=%0d hz=%b, expected rdy=%b we=%b pc=%h oc=%b occ=%0d hz=%b",
               nvec, upd_ready, wr_en, wr_pc, wr_outcome, occupancy, rd_hazard,
               e_rdy, m_iss, m_iss_e[16:1], m_iss_e[0], mq.size(), e_hz);
    end
    acc = v && e_rdy;
    pop = (mq.size() > 0) && !hold;
    m_iss = pop;
    if (pop) m_iss_e = mq.pop_front();
    if (acc) begin
      mq.push_back({pc, oc});
      accepted++;
    end
    @(negedge clk);
  endtask

  initial begin
    //          rst v  pc       oc fl hd rdpc      rdy we wpc      woc occ hz
    // reset state
    tbl.push_back(mk(1,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h0000,0,0,0));
    // single update: wr_en two cycles after accept
    tbl.push_back(mk(0,1,16'h0040,1,0,0,16'hFFFC, 1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'h0040, 1,0,16'h0000,0,1,1));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,1,16'h0040,1,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h0040,1,0,0));
    // hold, fill to full, fifth refused, release -> four pulses in order
    tbl.push_back(mk(0,1,16'h0100,1,0,1,16'hFFFC, 1,0,16'h0040,1,0,0));
    tbl.push_back(mk(0,1,16'h0204,0,0,1,16'hFFFC, 1,0,16'h0040,1,1,0));
    tbl.push_back(mk(0,1,16'h0308,1,0,1,16'hFFFC, 1,0,16'h0040,1,2,0));
    tbl.push_back(mk(0,1,16'h040C,0,0,1,16'hFFFC, 1,0,16'h0040,1,3,0));
    tbl.push_back(mk(0,1,16'h0510,1,0,1,16'hFFFC, 0,0,16'h0040,1,4,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 0,0,16'h0040,1,4,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,1,16'h0100,1,3,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,1,16'h0204,0,2,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,1,16'h0308,1,1,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,1,16'h040C,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h040C,0,0,0));
    // flush with 3 queued + 1 issuing and an incoming update
    tbl.push_back(mk(0,1,16'h0A00,1,0,1,16'hFFFC, 1,0,16'h040C,0,0,0));
    tbl.push_back(mk(0,1,16'h0A04,0,0,1,16'hFFFC, 1,0,16'h040C,0,1,0));
    tbl.push_back(mk(0,1,16'h0A08,1,0,1,16'hFFFC, 1,0,16'h040C,0,2,0));
    tbl.push_back(mk(0,1,16'h0A0C,0,0,1,16'hFFFC, 1,0,16'h040C,0,3,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 0,0,16'h040C,0,4,0));
    tbl.push_back(mk(0,1,16'h0BB0,1,1,0,16'hFFFC, 1,1,16'h0A00,1,3,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h0A00,1,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h0A00,1,0,0));
    // hazard: index match ignores tag bits, clears after the write issues
    tbl.push_back(mk(0,1,16'h0104,1,0,1,16'hF104, 1,0,16'h0A00,1,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,1,16'hF104, 1,0,16'h0A00,1,1,1));
    tbl.push_back(mk(0,0,16'h0000,0,0,1,16'h0108, 1,0,16'h0A00,1,1,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hF104, 1,0,16'h0A00,1,1,1));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hF104, 1,1,16'h0104,1,0,1));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hF104, 1,0,16'h0104,1,0,0));
    // flush on empty queue
    tbl.push_back(mk(0,0,16'h0000,0,1,0,16'hFFFC, 1,0,16'h0104,1,0,0));
    // reset mid-drain with two queued
    tbl.push_back(mk(0,1,16'h0C00,1,0,1,16'hFFFC, 1,0,16'h0104,1,0,0));
    tbl.push_back(mk(0,1,16'h0C04,1,0,1,16'hFFFC, 1,0,16'h0104,1,1,0));
    tbl.push_back(mk(0,1,16'h0C08,1,0,1,16'hFFFC, 1,0,16'h0104,1,2,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h0104,1,3,0));
    tbl.push_back(mk(1,1,16'h0C0C,1,0,0,16'h0C04, 1,1,16'h0C00,1,2,1));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'h0C04, 1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h0000,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,16'hFFFC, 1,0,16'h0000,0,0,0));

    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'hFFFC);
    repeat (2) @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].pc, tbl[i].oc, tbl[i].fl, tbl[i].hold, tbl[i].rdpc);
      #1;
      nvec++;
      if (upd_ready !== tbl[i].rdy || wr_en !== tbl[i].we || wr_pc !== tbl[i].wpc ||
          wr_outcome !== tbl[i].woc || occupancy !== tbl[i].occ || rd_hazard !== tbl[i].hz) begin
        nfail++;
        $display("FAIL row %0d: got rdy=%b we=%b pc=%h oc=%b occ=%0d hz=%b, expected rdy=%b we=%b pc=%h oc=%b occ=%0d hz=%b",
                 i, upd_ready, wr_en, wr_pc, wr_outcome, occupancy, rd_hazard,
                 tbl[i].rdy, tbl[i].we, tbl[i].wpc, tbl[i].woc, tbl[i].occ, tbl[i].hz);
      end
      @(negedge clk);
    end

    // back-pressure: fill under hold, then keep upd_valid high while draining
    for (int k = 0; k < DEPTH; k++) model_cycle(1'b1, 1'b1);
    for (int k = 0; k < 200 && accepted < DEPTH + 20; k++) model_cycle(1'b1, 1'b0);
    for (int k = 0; k < 20 && (mq.size() > 0 || m_iss); k++) model_cycle(1'b0, 1'b0);
    nvec++;
    if (accepted != DEPTH + 20 || mq.size() != 0 || m_iss) begin
      nfail++;
      $display("FAIL bp drain: accepted=%0d left=%0d issuing=%b, expected accepted=%0d left=0 issuing=0",
               accepted, mq.size(), m_iss, DEPTH + 20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
